// File: rtl/i2s_mic_array_tx.sv
// rtl/i2s_mic_array_tx.sv - I2S clock master serializing a 16-mic frame onto 8 data lines
module i2s_mic_array_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SLOT_W   = 32,
  parameter int SAMPLE_W = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [16*SAMPLE_W-1:0]  i_sample_data,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic                    o_bit_clk,
  output logic                    o_lr_clk,
  output logic [7:0]              o_sd,
  output logic                    o_frame_start,
  output logic                    o_underrun
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(2*SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(2*SLOT_W-1);
  localparam logic [IW-1:0] SLOT_I   = IW'(SLOT_W);
  localparam logic [IW-1:0] SAMP_I   = IW'(SAMPLE_W);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_div_cnt;
  logic [IW-1:0]           r_bit_idx;
  logic                    r_bit_clk;
  logic                    r_lr_clk;
  logic [7:0]              r_sd;
  logic                    r_frame_start;
  logic                    r_underrun;
  logic                    r_hold_full;
  logic [16*SAMPLE_W-1:0]  r_hold;
  logic [SAMPLE_W-1:0]     r_shift [16];

  state_t                  w_state_nxt;
  logic [DW-1:0]           w_div_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_bclk_nxt;
  logic                    w_lr_nxt;
  logic [7:0]              w_sd_nxt;
  logic                    w_load;
  logic                    w_fall;
  logic                    w_xfer;
  logic [IW-1:0]           w_idx_inc;
  logic [IW-1:0]           w_pos;
  logic                    w_lr_inc;
  logic                    w_emit;
  logic [7:0]              w_sd_line;

  assign o_sample_ready = !r_hold_full;
  assign o_bit_clk      = r_bit_clk;
  assign o_lr_clk       = r_lr_clk;
  assign o_sd           = r_sd;
  assign o_frame_start  = r_frame_start;
  assign o_underrun     = r_underrun;

  assign w_xfer    = i_sample_valid && !r_hold_full;
  assign w_idx_inc = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IW'(1);
  assign w_lr_inc  = (w_idx_inc >= SLOT_I);
  assign w_pos     = w_lr_inc ? (w_idx_inc - SLOT_I) : w_idx_inc;
  // One-bit I2S delay: slot position 0 is a blank bit before the MSB
  assign w_emit    = (w_pos != '0) && (w_pos <= SAMP_I);
  assign w_fall    = (r_state == S_RUN) && (r_div_cnt == DIV_LAST) && r_bit_clk;

  always_comb begin
    w_sd_line = '0;
    for (int k = 0; k < 8; k++) begin
      w_sd_line[k] = w_emit && (w_lr_inc ? r_shift[2*k+1][SAMPLE_W-1] : r_shift[2*k][SAMPLE_W-1]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_idx_nxt   = r_bit_idx;
    w_bclk_nxt  = r_bit_clk;
    w_lr_nxt    = r_lr_clk;
    w_sd_nxt    = r_sd;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt  = '0;
        w_idx_nxt  = '0;
        w_bclk_nxt = 1'b0;
        w_lr_nxt   = 1'b0;
        w_sd_nxt   = '0;
        if (i_enable) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt  = '0;
          w_bclk_nxt = !r_bit_clk;
          if (r_bit_clk) begin
            w_idx_nxt = w_idx_inc;
            w_lr_nxt  = w_lr_inc;
            w_sd_nxt  = w_sd_line;
            // Frame boundary: enable is only looked at here, so a drop finishes the frame
            if (w_idx_inc == '0) begin
              if (i_enable) w_load = 1'b1;
              else          w_state_nxt = S_IDLE;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + DW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_idx     <= '0;
      r_bit_clk     <= 1'b0;
      r_lr_clk      <= 1'b0;
      r_sd          <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_hold_full   <= 1'b0;
      r_hold        <= '0;
      for (int m = 0; m < 16; m++) r_shift[m] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_div_cnt     <= w_div_nxt;
      r_bit_idx     <= w_idx_nxt;
      r_bit_clk     <= w_bclk_nxt;
      r_lr_clk      <= w_lr_nxt;
      r_sd          <= w_sd_nxt;
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_hold_full;
      if (w_xfer) r_hold <= i_sample_data;
      // A sample arriving during an empty load is kept for the following frame
      if (w_load)      r_hold_full <= w_xfer;
      else if (w_xfer) r_hold_full <= 1'b1;
      for (int m = 0; m < 16; m++) begin
        if (w_load)
          r_shift[m] <= r_hold_full ? r_hold[m*SAMPLE_W +: SAMPLE_W] : '0;
        else if (w_fall && w_emit && (w_lr_inc == m[0]))
          r_shift[m] <= r_shift[m] << 1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_array_tx.sv
// tb/tb_i2s_mic_array_tx.sv - scoreboard bench for the I2S 16-mic transmitter
module tb_i2s_mic_array_tx;
  localparam int CLK_DIV  = 4;
  localparam int SLOT_W   = 32;
  localparam int SAMPLE_W = 24;
  localparam int FW       = 16*SAMPLE_W;
  localparam int NBITS    = 2*SLOT_W;

  typedef struct packed {
    logic [FW-1:0] data;
    logic          ur;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [FW-1:0] sample_data = '0;
  logic          sample_ready, bit_clk, lr_clk, frame_start, underrun;
  logic [7:0]    sd;

  always #5 clk = ~clk;

  i2s_mic_array_tx #(.CLK_DIV(CLK_DIV), .SLOT_W(SLOT_W), .SAMPLE_W(SAMPLE_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .i_sample_data(sample_data), .i_sample_valid(sample_valid),
    .o_sample_ready(sample_ready), .o_bit_clk(bit_clk), .o_lr_clk(lr_clk),
    .o_sd(sd), .o_frame_start(frame_start), .o_underrun(underrun)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: captures sd/lr on every bit_clk rise of a frame and checks clock timing
  int         cyc = 0, fs_t = 0, bc_t = 0, lr_rise_t = 0, cnt = 0, n_fs = 0, n_done = 0;
  bit         bc_valid = 0, lr_valid = 0, active = 0, acc_prev = 0;
  logic       prev_bclk = 1'b0, prev_lr = 1'b0;
  logic [7:0] cap_sd [NBITS];
  logic [63:0] cap_lr;
  exp_t       cur;

  task automatic compare_frame();
    logic [SAMPLE_W-1:0] obs;
    logic [7:0]          pad;
    int                  ln, base;
    for (int m = 0; m < 16; m++) begin
      ln   = m / 2;
      base = (m % 2 == 1) ? SLOT_W + 1 : 1;
      for (int b = 0; b < SAMPLE_W; b++) obs[SAMPLE_W-1-b] = cap_sd[base+b][ln];
      check_eq($sformatf("mic%0d", m), 64'(obs), 64'(cur.data[m*SAMPLE_W +: SAMPLE_W]));
    end
    pad = '0;
    for (int i = 0; i < NBITS; i++)
      if ((i % SLOT_W) == 0 || (i % SLOT_W) > SAMPLE_W) pad |= cap_sd[i];
    check_eq("pad_bits", 64'(pad), 64'h0);
    check_eq("lr_pattern", cap_lr, 64'hFFFFFFFF_00000000);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 0; bc_valid = 0; lr_valid = 0; acc_prev = 0;
    end else begin
      if (acc_prev) check_eq("ready_drop", 64'(sample_ready), 64'h0);
      acc_prev = sample_valid && sample_ready;
      if (bit_clk != prev_bclk) begin
        if (bc_valid) check_eq("bclk_half", 64'(cyc - bc_t), 64'(CLK_DIV));
        bc_t = cyc; bc_valid = 1;
      end else if (cyc - bc_t > CLK_DIV) begin
        bc_valid = 0;
      end
      if (frame_start) begin
        n_fs++; fs_t = cyc; active = 1; cnt = 0;
        check_eq("exp_queue_size", 64'(exp_q.size()), 64'h1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
        check_eq("underrun", 64'(underrun), 64'(cur.ur));
        if (!cur.ur) check_eq("ready_at_fs", 64'(sample_ready), 64'h1);
      end else if (underrun) begin
        check_eq("underrun_stray", 64'(underrun), 64'h0);
      end
      if (bit_clk && !prev_bclk && active) begin
        if (cnt == 0) check_eq("first_rise", 64'(cyc - fs_t), 64'(CLK_DIV));
        cap_sd[cnt] = sd;
        cap_lr[cnt] = lr_clk;
        cnt++;
        if (cnt == NBITS) begin
          compare_frame();
          active = 0;
          n_done++;
        end
      end
      if (lr_clk && !prev_lr) begin
        check_eq("lr_low", 64'(cyc - fs_t), 64'(2*CLK_DIV*SLOT_W));
        lr_rise_t = cyc; lr_valid = 1;
      end
      if (!lr_clk && prev_lr && lr_valid) begin
        check_eq("lr_high", 64'(cyc - lr_rise_t), 64'(2*CLK_DIV*SLOT_W));
        lr_valid = 0;
      end
    end
    prev_bclk = bit_clk;
    prev_lr   = lr_clk;
  end

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] d;
    for (int i = 0; i < FW/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send(input logic [FW-1:0] d);
    bit   done;
    exp_t e;
    done = 0;
    @(posedge clk); #1;
    sample_data  = d;
    sample_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sample_ready) done = 1;
    end
    @(posedge clk);
    if (done) begin
      e.data = d; e.ur = 1'b0;
      exp_q.push_back(e);
    end
    #1 sample_valid = 1'b0;
    check_eq("send_accepted", 64'(done), 64'h1);
  endtask

  task automatic wait_fs(input int target);
    int i;
    i = 0;
    while (n_fs < target && i < 3000) begin @(negedge clk); i++; end
    check_eq("frame_start_seen", 64'(n_fs >= target), 64'h1);
  endtask

  task automatic wait_done(input int target);
    int i;
    i = 0;
    while (n_done < target && i < 3000) begin @(negedge clk); i++; end
    check_eq("frame_done_seen", 64'(n_done >= target), 64'h1);
  endtask

  task automatic check_idle(input string tag);
    repeat (2*CLK_DIV) @(negedge clk);
    check_eq(tag, 64'({bit_clk, lr_clk, sd, frame_start, underrun}), 64'h0);
  endtask

  task automatic set_enable(input logic v);
    @(posedge clk); #1 enable = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] d;
    exp_t          z;
    int            f0, d0;
    z.data = '0;
    z.ur   = 1'b1;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", 64'({sample_ready, bit_clk, lr_clk, sd, frame_start, underrun}), 64'h1000);

    // Preloaded frame with known patterns
    d = '0;
    d[0 +: SAMPLE_W]         = 24'hA5A5A5;
    d[SAMPLE_W +: SAMPLE_W]  = 24'h5A5A5A;
    d[15*SAMPLE_W +: SAMPLE_W] = 24'h800001;
    send(d);
    f0 = n_fs; d0 = n_done;
    set_enable(1'b1);
    wait_fs(f0 + 1);
    set_enable(1'b0);
    wait_done(d0 + 1);
    check_idle("idle_after_preload");

    // Underrun frame followed by a sample given mid-frame
    f0 = n_fs; d0 = n_done;
    exp_q.push_back(z);
    set_enable(1'b1);
    wait_fs(f0 + 1);
    repeat (100) @(posedge clk);
    send(rand_frame());
    wait_fs(f0 + 2);
    set_enable(1'b0);
    wait_done(d0 + 2);
    check_idle("idle_after_underrun");

    // Streaming four back-to-back frames
    f0 = n_fs; d0 = n_done;
    send(rand_frame());
    set_enable(1'b1);
    for (int i = 0; i < 3; i++) send(rand_frame());
    wait_fs(f0 + 4);
    set_enable(1'b0);
    wait_done(d0 + 4);
    check_idle("idle_after_stream");

    // Enable dropped around bit_idx 10, then re-enabled
    f0 = n_fs; d0 = n_done;
    send(rand_frame());
    set_enable(1'b1);
    wait_fs(f0 + 1);
    repeat (10*2*CLK_DIV) @(posedge clk);
    #1 enable = 1'b0;
    wait_done(d0 + 1);
    check_idle("idle_after_drop");
    send(rand_frame());
    set_enable(1'b1);
    wait_fs(f0 + 2);
    set_enable(1'b0);
    wait_done(d0 + 2);
    check_idle("idle_after_reenable");

    // Reset in the right slot with a sample held
    f0 = n_fs;
    send(rand_frame());
    set_enable(1'b1);
    wait_fs(f0 + 1);
    send(rand_frame());
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_midframe", 64'({sample_ready, bit_clk, lr_clk, sd}), 64'h400);
    f0 = n_fs; d0 = n_done;
    exp_q.push_back(z);
    set_enable(1'b1);
    wait_fs(f0 + 1);
    set_enable(1'b0);
    wait_done(d0 + 1);
    check_idle("idle_after_reset_test");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
